// File: rtl/jt1943_rom_arbiter.sv
// Round-robin arbiter that funnels up to four ROM cache misses onto one SDRAM
// read port and returns the two assembled 16-bit beats as one 32-bit word.
module jt1943_rom_arbiter #(
  parameter int            SAW     = 20,
  parameter int            AW      = 22,
  parameter logic [AW-1:0] OFFSET0 = 22'h000000,
  parameter logic [AW-1:0] OFFSET1 = 22'h040000,
  parameter logic [AW-1:0] OFFSET2 = 22'h080000,
  parameter logic [AW-1:0] OFFSET3 = 22'h0C0000
) (
  input  logic             rst,
  input  logic             clk,
  input  logic [3:0]       slot_req_i,
  input  logic [4*SAW-1:0] slot_addr_i,
  output logic [3:0]       slot_we_o,
  output logic [31:0]      slot_dout_o,
  output logic             sdram_req_o,
  output logic [AW-1:0]    sdram_addr_o,
  input  logic             sdram_ack_i,
  input  logic             sdram_dst_i,
  input  logic [15:0]      sdram_din_i
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] WAIT_ACK = 3'd1;
  localparam logic [2:0] BEAT0    = 3'd2;
  localparam logic [2:0] BEAT1    = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;

  logic [2:0]     state_q, state_d;
  logic [1:0]     last_q, last_d;
  logic [1:0]     win_q, win_d;
  logic [SAW-3:0] tag_q, tag_d;
  logic           sdram_req_q, sdram_req_d;
  logic [AW-1:0]  sdram_addr_q, sdram_addr_d;
  logic [31:0]    dout_q, dout_d;

  logic [1:0]     rr_win_s;
  logic [1:0]     cand_s;
  logic           rr_found_s;
  logic [SAW-1:0] rr_addr_s;
  logic [SAW-1:0] cur_addr_s;
  logic           hit_s;
  logic           addr_lsb_unused_s;

  function automatic logic [AW-1:0] region_base(input logic [1:0] slot);
    case (slot)
      2'd0:    region_base = OFFSET0;
      2'd1:    region_base = OFFSET1;
      2'd2:    region_base = OFFSET2;
      2'd3:    region_base = OFFSET3;
      default: region_base = OFFSET0;
    endcase
  endfunction

  // Round-robin search starting one past the last served slot.
  always_comb begin
    rr_win_s   = last_q;
    rr_found_s = 1'b0;
    cand_s     = 2'd0;
    for (int i = 1; i < 5; i++) begin
      cand_s = last_q + 2'(i);
      if (!rr_found_s && slot_req_i[cand_s]) begin
        rr_win_s   = cand_s;
        rr_found_s = 1'b1;
      end else begin
        rr_found_s = rr_found_s;
      end
    end
    rr_addr_s = slot_addr_i[rr_win_s*SAW +: SAW];
  end

  // The client may have moved on while the burst was in flight.
  always_comb begin
    cur_addr_s        = slot_addr_i[win_q*SAW +: SAW];
    hit_s             = slot_req_i[win_q] && (cur_addr_s[SAW-1:2] == tag_q);
    addr_lsb_unused_s = ^{rr_addr_s[0], cur_addr_s[1:0]};
  end

  always_comb begin
    if (state_q == DONE && hit_s) begin
      slot_we_o = 4'b0001 << win_q;
    end else begin
      slot_we_o = 4'b0000;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    win_d        = win_q;
    tag_d        = tag_q;
    sdram_req_d  = sdram_req_q;
    sdram_addr_d = sdram_addr_q;
    dout_d       = dout_q;
    case (state_q)
      IDLE: begin
        if (rr_found_s) begin
          win_d        = rr_win_s;
          tag_d        = rr_addr_s[SAW-1:2];
          sdram_addr_d = region_base(rr_win_s) + AW'(rr_addr_s[SAW-1:1]);
          sdram_req_d  = 1'b1;
          state_d      = WAIT_ACK;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_ACK: begin
        if (sdram_ack_i) begin
          sdram_req_d = 1'b0;
          state_d     = BEAT0;
        end else begin
          state_d = WAIT_ACK;
        end
      end
      BEAT0: begin
        if (sdram_dst_i) begin
          dout_d  = {dout_q[31:16], sdram_din_i};
          state_d = BEAT1;
        end else begin
          state_d = BEAT0;
        end
      end
      BEAT1: begin
        if (sdram_dst_i) begin
          dout_d  = {sdram_din_i, dout_q[15:0]};
          state_d = DONE;
        end else begin
          state_d = BEAT1;
        end
      end
      DONE: begin
        last_d  = win_q;
        state_d = IDLE;
      end
      default: begin
        sdram_req_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // Last-served starts at 3 so slot 0 wins the first arbitration.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_q       <= 2'd3;
      win_q        <= 2'd0;
      tag_q        <= '0;
      sdram_req_q  <= 1'b0;
      sdram_addr_q <= '0;
      dout_q       <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      win_q        <= win_d;
      tag_q        <= tag_d;
      sdram_req_q  <= sdram_req_d;
      sdram_addr_q <= sdram_addr_d;
      dout_q       <= dout_d;
    end
  end

  assign sdram_req_o  = sdram_req_q;
  assign sdram_addr_o = sdram_addr_q;
  assign slot_dout_o  = dout_q;

endmodule

// File: tb/tb_jt1943_rom_arbiter.sv
// Scoreboard bench for jt1943_rom_arbiter: an SDRAM responder checks request
// addresses, a monitor pops expected strobes/data, and a client model drops req.
module tb_jt1943_rom_arbiter;
  localparam int SAW = 20;
  localparam int AW  = 22;
  localparam logic [21:0] OFF0 = 22'h000000;
  localparam logic [21:0] OFF1 = 22'h040000;
  localparam logic [21:0] OFF2 = 22'h080000;
  localparam logic [21:0] OFF3 = 22'h3FFFF0;

  typedef struct packed {
    logic [1:0]  slot;
    logic [31:0] data;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       slot_req_i;
  logic [4*SAW-1:0] slot_addr_i;
  logic [3:0]       slot_we_o;
  logic [31:0]      slot_dout_o;
  logic             sdram_req_o;
  logic [AW-1:0]    sdram_addr_o;
  logic             sdram_ack_i;
  logic             sdram_dst_i;
  logic [15:0]      sdram_din_i;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ack_delay = 0;
  int gap = 0;
  int req_in_burst = 0;
  bit auto_drop = 1'b1;

  exp_t        sb_q[$];
  logic [21:0] addr_q[$];
  logic [15:0] beat_q[$];
  int          we_cyc_q[$];

  jt1943_rom_arbiter #(
    .SAW(SAW), .AW(AW),
    .OFFSET0(OFF0), .OFFSET1(OFF1), .OFFSET2(OFF2), .OFFSET3(OFF3)
  ) dut (
    .rst(rst), .clk(clk),
    .slot_req_i(slot_req_i), .slot_addr_i(slot_addr_i),
    .slot_we_o(slot_we_o), .slot_dout_o(slot_dout_o),
    .sdram_req_o(sdram_req_o), .sdram_addr_o(sdram_addr_o),
    .sdram_ack_i(sdram_ack_i), .sdram_dst_i(sdram_dst_i), .sdram_din_i(sdram_din_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [15:0] model_beat(input logic [21:0] a, input bit hi);
    return hi ? (a[15:0] ^ 16'hA5A5) : (a[15:0] + 16'h1357);
  endfunction

  function automatic logic [31:0] model_word(input logic [21:0] a);
    return {model_beat(a, 1'b1), model_beat(a, 1'b0)};
  endfunction

  task automatic set_addr(input int n, input logic [19:0] v);
    slot_addr_i[n*SAW +: SAW] = v;
  endtask

  task automatic wait_drain(input int lim);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < lim) begin
      @(posedge clk);
      n++;
    end
  endtask

  // SDRAM controller model: checks the request address, acks, returns two beats.
  initial begin
    logic [21:0] a, e;
    logic [15:0] b0, b1;
    sdram_ack_i = 1'b0;
    sdram_dst_i = 1'b0;
    sdram_din_i = 16'h0000;
    forever begin
      @(negedge clk);
      if (sdram_req_o === 1'b1) begin
        a = sdram_addr_o;
        total++;
        if (addr_q.size() == 0) begin
          bad++;
          $display("FAIL sdram_addr: unexpected request addr=%h", a);
        end else begin
          e = addr_q.pop_front();
          if (a !== e) begin
            bad++;
            $display("FAIL sdram_addr: got %h want %h", a, e);
          end
        end
        repeat (ack_delay) begin
          @(negedge clk);
          total++;
          if (sdram_req_o !== 1'b1 || sdram_addr_o !== a) begin
            bad++;
            $display("FAIL req_hold: req=%b addr=%h want req=1 addr=%h", sdram_req_o, sdram_addr_o, a);
          end
        end
        sdram_ack_i = 1'b1;
        @(negedge clk);
        sdram_ack_i = 1'b0;
        b0 = (beat_q.size() != 0) ? beat_q.pop_front() : model_beat(a, 1'b0);
        b1 = (beat_q.size() != 0) ? beat_q.pop_front() : model_beat(a, 1'b1);
        sdram_dst_i = 1'b1;
        sdram_din_i = b0;
        @(negedge clk);
        if (sdram_req_o) req_in_burst++;
        if (gap > 0) begin
          sdram_dst_i = 1'b0;
          sdram_din_i = 16'hDEAD;
          repeat (gap) begin
            @(negedge clk);
            if (sdram_req_o) req_in_burst++;
          end
        end
        sdram_dst_i = 1'b1;
        sdram_din_i = b1;
        @(negedge clk);
        sdram_dst_i = 1'b0;
        sdram_din_i = 16'hBAD0;
      end
    end
  end

  // Strobe monitor and client model: compares each slot_we against the scoreboard.
  initial begin
    logic [3:0] w;
    exp_t ex;
    forever begin
      @(negedge clk);
      if (slot_we_o !== 4'b0000) begin
        w = slot_we_o;
        total++;
        if (sb_q.size() == 0) begin
          bad++;
          $display("FAIL strobe: unexpected we=%b dout=%h want none", w, slot_dout_o);
        end else begin
          ex = sb_q.pop_front();
          if (w !== (4'b0001 << ex.slot) || slot_dout_o !== ex.data) begin
            bad++;
            $display("FAIL strobe: got we=%b dout=%h want we=%b dout=%h",
                     w, slot_dout_o, 4'b0001 << ex.slot, ex.data);
          end
        end
        we_cyc_q.push_back(cyc);
        if (auto_drop) begin
          @(posedge clk);
          #1;
          slot_req_i = slot_req_i & ~w;
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    slot_req_i = 4'b0000;
    slot_addr_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (sdram_req_o !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", sdram_req_o); end
    total++; if (sdram_addr_o !== 22'h000000) begin bad++; $display("FAIL reset_addr: got %h want 000000", sdram_addr_o); end
    total++; if (slot_we_o !== 4'b0000) begin bad++; $display("FAIL reset_we: got %b want 0000", slot_we_o); end
    total++; if (slot_dout_o !== 32'h0) begin bad++; $display("FAIL reset_dout: got %h want 0", slot_dout_o); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single();
    ack_delay = 3;
    beat_q.push_back(16'h3412);
    beat_q.push_back(16'h7856);
    addr_q.push_back(22'h000082);
    sb_q.push_back('{slot: 2'd0, data: 32'h78563412});
    @(posedge clk); #1;
    set_addr(0, 20'h00104);
    slot_req_i = 4'b0001;
    wait_drain(80);
    total++; if (sb_q.size() != 0 || addr_q.size() != 0) begin bad++; $display("FAIL single: pending sb=%0d addr=%0d want 0", sb_q.size(), addr_q.size()); end
    sb_q.delete(); addr_q.delete();
    ack_delay = 0;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_offset_wrap();
    addr_q.push_back(22'h07FFEE);
    sb_q.push_back('{slot: 2'd3, data: model_word(22'h07FFEE)});
    @(posedge clk); #1;
    set_addr(3, 20'hFFFFC);
    slot_req_i = 4'b1000;
    wait_drain(60);
    total++; if (sb_q.size() != 0 || addr_q.size() != 0) begin bad++; $display("FAIL wrap: pending sb=%0d addr=%0d want 0", sb_q.size(), addr_q.size()); end
    sb_q.delete(); addr_q.delete();
    repeat (3) @(posedge clk);
  endtask

  task automatic test_round_robin();
    logic [21:0] ea [4];
    ea[0] = 22'h000080;
    ea[1] = 22'h040100;
    ea[2] = 22'h080180;
    ea[3] = 22'h0001F0;
    auto_drop = 1'b0;
    we_cyc_q.delete();
    for (int i = 0; i < 5; i++) begin
      addr_q.push_back(ea[i % 4]);
      sb_q.push_back('{slot: 2'(i % 4), data: model_word(ea[i % 4])});
    end
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) set_addr(i, 20'(20'h00100 * (i + 1)));
    slot_req_i = 4'b1111;
    wait_drain(200);
    #1;
    slot_req_i = 4'b0000;
    total++; if (sb_q.size() != 0 || addr_q.size() != 0) begin bad++; $display("FAIL rr_drain: pending sb=%0d addr=%0d want 0", sb_q.size(), addr_q.size()); end
    total++; if (we_cyc_q.size() != 5) begin bad++; $display("FAIL rr_count: got %0d strobes want 5", we_cyc_q.size()); end
    for (int i = 1; i < we_cyc_q.size(); i++) begin
      total++;
      if (we_cyc_q[i] - we_cyc_q[i-1] != 5) begin
        bad++;
        $display("FAIL rr_cadence: interval %0d got %0d want 5", i, we_cyc_q[i] - we_cyc_q[i-1]);
      end
    end
    sb_q.delete(); addr_q.delete();
    repeat (8) @(posedge clk);
    auto_drop = 1'b1;
  endtask

  task automatic test_addr_change();
    int n;
    addr_q.push_back(22'h040008);
    addr_q.push_back(22'h040010);
    sb_q.push_back('{slot: 2'd1, data: model_word(22'h040010)});
    @(posedge clk); #1;
    set_addr(1, 20'h00010);
    slot_req_i = 4'b0010;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (sdram_ack_i !== 1'b1 && n < 50);
    #1;
    set_addr(1, 20'h00020);
    total++; if (n >= 50) begin bad++; $display("FAIL chg_ack: no ack after %0d cycles want <50", n); end
    wait_drain(80);
    total++; if (sb_q.size() != 0 || addr_q.size() != 0) begin bad++; $display("FAIL chg: pending sb=%0d addr=%0d want 0", sb_q.size(), addr_q.size()); end
    sb_q.delete(); addr_q.delete();
    repeat (3) @(posedge clk);
  endtask

  task automatic test_reset_mid_burst();
    int n;
    bit seen_we, seen_req;
    gap = 4;
    addr_q.push_back(22'h000000);
    sb_q.push_back('{slot: 2'd0, data: model_word(22'h000000)});
    @(posedge clk); #1;
    set_addr(0, 20'h00000);
    slot_req_i = 4'b0001;
    wait_drain(80);
    repeat (2) @(posedge clk);
    addr_q.push_back(22'h040020);
    #1;
    set_addr(1, 20'h00040);
    slot_req_i = 4'b0010;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (sdram_dst_i !== 1'b1 && n < 50);
    #1;
    rst = 1'b1;
    slot_req_i = 4'b0000;
    @(posedge clk); #1;
    rst = 1'b0;
    seen_we = 1'b0;
    seen_req = 1'b0;
    @(negedge clk);
    total++; if (slot_dout_o !== 32'h0) begin bad++; $display("FAIL rst_mid_dout: got %h want 0", slot_dout_o); end
    repeat (10) begin
      @(negedge clk);
      if (slot_we_o !== 4'b0000) seen_we = 1'b1;
      if (sdram_req_o !== 1'b0) seen_req = 1'b1;
    end
    total++; if (seen_we) begin bad++; $display("FAIL rst_mid_we: got strobe want none"); end
    total++; if (seen_req) begin bad++; $display("FAIL rst_mid_req: got req=1 want 0"); end
    gap = 0;
    addr_q.push_back(22'h000000);
    addr_q.push_back(22'h040020);
    sb_q.push_back('{slot: 2'd0, data: model_word(22'h000000)});
    sb_q.push_back('{slot: 2'd1, data: model_word(22'h040020)});
    @(posedge clk); #1;
    slot_req_i = 4'b0011;
    wait_drain(100);
    total++; if (sb_q.size() != 0 || addr_q.size() != 0) begin bad++; $display("FAIL rst_mid_after: pending sb=%0d addr=%0d want 0", sb_q.size(), addr_q.size()); end
    sb_q.delete(); addr_q.delete();
    repeat (3) @(posedge clk);
  endtask

  task automatic test_gapped_beats();
    gap = 4;
    req_in_burst = 0;
    beat_q.push_back(16'hBEEF);
    beat_q.push_back(16'hCAFE);
    addr_q.push_back(22'h080004);
    sb_q.push_back('{slot: 2'd2, data: 32'hCAFEBEEF});
    @(posedge clk); #1;
    set_addr(2, 20'h00008);
    slot_req_i = 4'b0100;
    wait_drain(80);
    total++; if (sb_q.size() != 0 || addr_q.size() != 0) begin bad++; $display("FAIL gap: pending sb=%0d addr=%0d want 0", sb_q.size(), addr_q.size()); end
    total++; if (req_in_burst != 0) begin bad++; $display("FAIL gap_req: req high %0d cycles want 0", req_in_burst); end
    sb_q.delete(); addr_q.delete();
    gap = 0;
    repeat (5) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_offset_wrap();
    test_round_robin();
    test_addr_change();
    test_reset_mid_burst();
    test_gapped_beats();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/jt1943_rom_arbiter.md
Name: jt1943_rom_arbiter

Overview:
- Downstream stage of the per-client ROM request caches: arbitrates up to four cache-miss requests onto one SDRAM read port.
- Assembles the two 16-bit SDRAM beats into one 32-bit word and returns it with a one-cycle write strobe to the winning client cache.
- Sits between the video/CPU ROM caches and the SDRAM controller in the 1943 core.

Parameters:
- SAW, 20, slot (client) address width; client addresses are byte addresses, 32-bit aligned by the client (addr[1:0]=0).
- AW, 22, SDRAM 16-bit-word address width.
- OFFSET0, 22'h000000, SDRAM word base of slot 0 region.
- OFFSET1, 22'h040000, SDRAM word base of slot 1 region.
- OFFSET2, 22'h080000, SDRAM word base of slot 2 region.
- OFFSET3, 22'h0C0000, SDRAM word base of slot 3 region.

Ports:
- rst  in  1  synchronous reset, active-high
- clk  in  1  system clock (clients run with cen=1 on this clk)
- slot_req  in  4  per-slot miss request, level, held until served
- slot_addr  in  4*SAW  packed slot byte addresses; slot n at [n*SAW +: SAW]
- slot_we  out  4  one-hot, one-cycle data-valid strobe to slot n
- slot_dout  out  32  assembled data word shared by all slots
- sdram_req  out  1  read request to SDRAM controller
- sdram_addr  out  AW  SDRAM word address of the first beat
- sdram_ack  in  1  controller accepted the request (one-cycle pulse)
- sdram_dst  in  1  data beat valid
- sdram_din  in  16  beat data

Behaviour:
- Reset: state IDLE; sdram_req=0, sdram_addr=0, slot_we=0, slot_dout=0, last-served pointer=3 (so slot 0 wins first).
- SDRAM address = OFFSET_n + (slot_addr_n >> 1); client bits [1:0] ignored; sum truncated to AW bits (wraps).
- Arbitration: round robin. Search starts at last-served+1 modulo 4; the first slot with slot_req=1 wins.
- FSM states and transitions:
  - IDLE: if any slot_req, latch winner index and its SAW address, drive sdram_addr, set sdram_req=1 -> WAIT_ACK (1-cycle arbitration latency).
  - WAIT_ACK: hold sdram_req and sdram_addr stable; on sdram_ack, clear sdram_req -> BEAT0.
  - BEAT0: on sdram_dst, capture sdram_din into slot_dout[15:0] -> BEAT1.
  - BEAT1: on sdram_dst, capture into slot_dout[31:16] -> DONE. Beats may arrive back-to-back or with gaps.
  - DONE: compare latched address with current slot_addr of the winner, bits [SAW-1:2].
    - Match and slot_req still high: slot_we[winner]=1 for exactly this cycle.
    - Otherwise (client moved on): no strobe; the stale data is dropped.
    - Either way, update last-served and go to IDLE.
- The next arbitration happens no earlier than the cycle after DONE. The client cache has registered the strobe by then, so its req has already dropped on a hit and cannot be double-served.
- sdram_ack while in IDLE/BEAT0/BEAT1/DONE: ignored.
- sdram_dst outside BEAT0/BEAT1: ignored, including beats still arriving after a mid-burst reset.
- slot_req falling during WAIT_ACK/BEAT*: the transaction completes and is suppressed in DONE.
- slot_dout changes only in BEAT0/BEAT1; it is stable on the slot_we cycle.
- Reset asserted in any state: next cycle is IDLE with all outputs at reset values; no slot_we is issued for the aborted transfer.
- Throughput: minimum 5 cycles per transfer with immediate ack and back-to-back beats (IDLE, WAIT_ACK, BEAT0, BEAT1, DONE).

Test Plan:
- Single request: slot0 req, addr=20'h00104, ack after 3 cycles, beats 16'h3412 then 16'h7856 -> sdram_addr=22'h000082, slot_we=4'b0001 for one cycle, slot_dout=32'h78563412.
- Offset/wrap: slot3 addr=20'hFFFFC, OFFSET3=22'h3FFFF0 -> sdram_addr=22'h07FFEE truncated to 22 bits (0x3FFFF0+0x7FFFE mod 2^22); slot_we=4'b1000.
- Round robin: all four slot_req held high, immediate ack/beats -> service order 0,1,2,3,0; each slot_we one-hot, once per 5-cycle transfer.
- Address change mid-transfer: slot1 addr changes from 20'h00010 to 20'h00020 during BEAT0 -> no slot_we for the first transfer; next IDLE issues sdram_addr=OFFSET1+22'h10, then slot_we=4'b0010.
- Reset mid-burst: rst pulsed in BEAT1, controller still delivers a beat -> beat ignored, slot_we stays 0, sdram_req=0, next request starts from slot 0.
- Gapped beats: 4 idle cycles between sdram_dst beats -> slot_dout correct, single slot_we, sdram_req stays low throughout.
